seg_display_controller: RTL

- Time-multiplexed scan controller for the board's 8-digit, common-anode seven-segment display.
- Shares the display between eight 32-bit data sources: syscall output, RAM word at the check address, PC, cycle and branch statistics.
- `functionNumber` selects the source.
- Sits between the CPU top level and the `anode`/`cathode` pins. The value is sampled once per frame, so a digit never shows a mix of old and new data.

---
 rtl/seg_display_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seg_display_controller.sv
// seg_display_controller
// Scan controller for an 8-digit, common-anode seven-segment display.
// One of eight 32-bit sources (picked by functionNumber) is latched once per
// frame, at the digit 7 -> digit 0 wrap, so a frame never mixes old and new
// data. Each digit slot lasts SCAN_DIV cycles. The first GUARD_CYCLES cycles
// of a slot keep every anode off to suppress ghosting.
// Anode, cathode and frameStart are registered one cycle behind the counters.
//
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN
//   When defined, leading-zero digits are blanked. Digit 0 is always lit.
//   Scan timing and frameStart behave the same in both builds.

module seg_display_controller #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [2:0]   functionNumber,
  input  logic [255:0] sources,
  output logic [7:0]   anode,
  output logic [7:0]   cathode,
  output logic         frameStart,
  output logic [31:0]  shownValue
);

  localparam int            PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST_C  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_C = PW'(GUARD_CYCLES);

  // Map a hex nibble to its active-low {dp,g,f,e,d,c,b,a} pattern. The dp bit stays off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Active-low one-cold enable for a digit index.
  function automatic logic [7:0] digit_enable(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction

  logic [PW-1:0] prescale_r;
  logic [2:0]    digit_r;
  logic [31:0]   shown_r;
  logic [7:0]    anode_r;
  logic [7:0]    cathode_r;
  logic          frame_start_r;

  logic          slot_end_s;
  logic          frame_end_s;
  logic [3:0]    nibble_s;
  logic          blank_s;
  logic [7:0]    anode_nxt_s;
  logic [7:0]    cathode_nxt_s;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [31:0]   upper_s;
`endif

  // Decode slot/frame boundaries and the next anode/cathode drive from the current counters.
  always_comb begin
    slot_end_s    = (prescale_r == LAST_C);
    frame_end_s   = slot_end_s && (digit_r == 3'd7);
    nibble_s      = shown_r[{digit_r, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is blank when its nibble and every nibble above it are zero.
    upper_s       = shown_r >> {digit_r, 2'b00};
    blank_s       = (digit_r != 3'd0) && (upper_s == 32'd0);
`else
    blank_s       = 1'b0;
`endif
    anode_nxt_s   = 8'hFF;
    cathode_nxt_s = 8'hFF;
    if ((prescale_r < GUARD_C) || blank_s) begin
      anode_nxt_s = 8'hFF;
    end else begin
      anode_nxt_s = digit_enable(digit_r);
    end
    if (blank_s) begin
      cathode_nxt_s = 8'hFF;
    end else begin
      cathode_nxt_s = hex_to_seg(nibble_s);
    end
  end

  // Prescaler and digit index. The digit index advances once per slot and wraps modulo 8.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescale_r <= '0;
      digit_r    <= 3'd0;
    end else if (slot_end_s) begin
      prescale_r <= '0;
      digit_r    <= digit_r + 3'd1;
    end else begin
      prescale_r <= prescale_r + 1'b1;
    end
  end

  // Latch the selected source only at the 7->0 wrap, so a frame always shows one value.
  always_ff @(posedge clock) begin
    if (reset) begin
      shown_r <= 32'd0;
    end else if (frame_end_s) begin
      shown_r <= sources[{functionNumber, 5'b00000} +: 32];
    end else begin
      shown_r <= shown_r;
    end
  end

  // Registered pin drivers and the one-cycle frame pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      anode_r       <= 8'hFF;
      cathode_r     <= 8'hFF;
      frame_start_r <= 1'b0;
    end else begin
      anode_r       <= anode_nxt_s;
      cathode_r     <= cathode_nxt_s;
      frame_start_r <= frame_end_s;
    end
  end

  assign anode      = anode_r;
  assign cathode    = cathode_r;
  assign frameStart = frame_start_r;
  assign shownValue = shown_r;

endmodule
